load_store_unit: RTL and testbench

- Sequences every MEM-stage load/store of the pipelined MIPS core against a single-port data memory with a req/ack handshake.
- Generates byte enables and replicates store data into the correct byte lanes.
- Sign- or zero-extends sub-word load data to a full `WORD.
- Stalls the pipeline while an access is outstanding and flags misaligned addresses.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_load_align.sv | 40 ++++
 rtl/load_store_unit.sv | 207 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: word width, LSU op encodings,
// FSM state encodings and small op-classification helpers.
package load_store_unit_pkg;

    localparam int WORD = 32;

    typedef enum logic [2:0] {
        LSU_LB  = 3'b000,
        LSU_LBU = 3'b001,
        LSU_LH  = 3'b010,
        LSU_LHU = 3'b011,
        LSU_LW  = 3'b100,
        LSU_SB  = 3'b101,
        LSU_SH  = 3'b110,
        LSU_SW  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Halves need an even address, words a 4-byte aligned address.
    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return lo[0];
            LSU_LW, LSU_SW:          return |lo;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory word
// (little-endian lanes) and sign- or zero-extends it to a full word.
module load_store_unit_load_align
    import load_store_unit_pkg::*;
(
    input  lsu_op_e          op,
    input  logic [1:0]       byte_sel,
    input  logic [WORD-1:0]  mem_rdata,
    output logic [WORD-1:0]  result
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign byte_lane[gi] = mem_rdata[8*gi +: 8];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign half_lane[gi] = mem_rdata[16*gi +: 16];
    end

    // Select the addressed field and extend it according to the load type.
    always_comb begin
        byte_v = byte_lane[byte_sel];
        half_v = half_lane[byte_sel[1]];
        result = '0;
        case (op)
            LSU_LB:  result = {{24{byte_v[7]}}, byte_v};
            LSU_LBU: result = {{24{1'b0}}, byte_v};
            LSU_LH:  result = {{16{half_v[15]}}, half_v};
            LSU_LHU: result = {{16{1'b0}}, half_v};
            LSU_LW:  result = mem_rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding access against a single-port
// data memory with a req/ack handshake, store lane steering, load extension,
// pipeline stall and misalignment detection.
// Optional ack timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WORD-1:0]  addr,
    input  logic [WORD-1:0]  wdata,
    output logic             rsp_valid,
    output logic [WORD-1:0]  rdata,
    output logic             addr_err,
    output logic             bus_err,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [WORD-1:0]  mem_addr,
    output logic [WORD-1:0]  mem_wdata,
    input  logic             mem_ack,
    input  logic [WORD-1:0]  mem_rdata
);

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("load_store_unit: MEM_TIMEOUT must be in 1..255");
    end

    lsu_state_e       state_q, state_d;
    lsu_op_e          op_q, op_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WORD-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD-1:0]  mem_wdata_q, mem_wdata_d;
    logic [WORD-1:0]  rdata_q, rdata_d;
    logic             addr_err_q, addr_err_d;
    logic             bus_err_q, bus_err_d;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    logic [7:0]       cnt_q, cnt_d;
`endif

    lsu_op_e          op_in;
    logic [3:0]       st_be;
    logic [WORD-1:0]  st_wdata;
    logic [WORD-1:0]  load_result;

    assign op_in = lsu_op_e'(op);

    load_store_unit_load_align u_load_align (
        .op        (op_q),
        .byte_sel  (addr_lo_q),
        .mem_rdata (mem_rdata),
        .result    (load_result)
    );

    // Byte enables and lane-replicated store data for the incoming op.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = '0;
        case (op_in)
            LSU_SB: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            LSU_SH: begin
                st_be    = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            LSU_SW: begin
                st_be    = 4'b1111;
                st_wdata = wdata;
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = '0;
            end
        endcase
    end

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        addr_err_d  = addr_err_q;
        bus_err_d   = bus_err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = op_in;
                    addr_lo_d  = addr[1:0];
                    rdata_d    = '0;
                    bus_err_d  = 1'b0;
                    addr_err_d = is_misaligned(op_in, addr[1:0]);
                    if (is_misaligned(op_in, addr[1:0])) begin
                        // Misaligned ops never reach memory.
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store(op_in);
                        mem_be_d    = st_be;
                        mem_addr_d  = {addr[WORD-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
`ifdef LSU_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = is_store(op_q) ? '0 : load_result;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    // Give up on the memory; an ack this same cycle would have won.
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= LSU_LB;
            addr_lo_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign stall     = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_ACCESS);
    assign rdata     = rdata_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: scripted per-cycle driver with a transaction
// level reference, and a single compare process on the falling edge.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int TB_TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_TIMEOUT(TB_TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the current cycle, written by the driver.
    logic        e_chk = 1'b0;
    logic        e_full = 1'b0;
    logic        e_ready, e_stall, e_req, e_we, e_rsp, e_aerr, e_berr;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Compare process: one line per transaction response.
    always @(negedge clk) begin
        if (e_chk) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("stall",     32'(stall),     32'(e_stall));
            chk("mem_req",   32'(mem_req),   32'(e_req));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_req || e_full) begin
                chk("mem_we",   32'(mem_we), 32'(e_we));
                chk("mem_be",   32'(mem_be), 32'(e_be));
                chk("mem_addr", mem_addr,    e_addr);
            end
            if ((e_req && e_we) || e_full)
                chk("mem_wdata", mem_wdata, e_wdata);
            if (e_rsp || e_full) begin
                chk("rdata",    rdata,          e_rdata);
                chk("addr_err", 32'(addr_err),  32'(e_aerr));
                chk("bus_err",  32'(bus_err),   32'(e_berr));
            end
            if (e_rsp)
                $display("rsp cyc=%0d rdata=%h addr_err=%0d bus_err=%0d", cyc, rdata, addr_err, bus_err);
        end
    end

    // ---------------- reference rules ----------------
    function automatic logic ref_mis(input logic [2:0] o, input logic [31:0] a);
        if (o == 3'd2 || o == 3'd3 || o == 3'd6) return (a % 2) != 0;
        if (o == 3'd4 || o == 3'd7) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] w);
        int bv;
        int hv;
        bv = int'((w >> (8 * (a % 4))) & 32'd255);
        hv = int'((w >> (16 * ((a / 2) % 2))) & 32'd65535);
        case (o)
            3'd0:    return 32'(bv >= 128 ? bv - 256 : bv);
            3'd1:    return 32'(bv);
            3'd2:    return 32'(hv >= 32768 ? hv - 65536 : hv);
            3'd3:    return 32'(hv);
            3'd4:    return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] o, input logic [31:0] a);
        if (o == 3'd5) return 4'(1 << (a % 4));
        if (o == 3'd6) return ((a / 2) % 2) != 0 ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] o, input logic [31:0] wd);
        if (o == 3'd5) return (wd & 32'd255) * 32'h0101_0101;
        if (o == 3'd6) return (wd & 32'd65535) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle(input logic v);
        e_full  = 1'b0;
        e_ready = 1'b1;
        e_stall = v;
        e_req   = 1'b0;
        e_rsp   = 1'b0;
    endtask

    task automatic exp_reset_state();
        exp_idle(1'b0);
        e_full  = 1'b1;
        e_we    = 1'b0;
        e_be    = 4'h0;
        e_addr  = 32'd0;
        e_wdata = 32'd0;
        e_rdata = 32'd0;
        e_aerr  = 1'b0;
        e_berr  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            req_valid = 1'b0;
            op        = 3'($urandom);
            addr      = $urandom;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            exp_idle(1'b0);
        end
    endtask

    // One complete transaction; lit_en forces a hand-computed load result.
    task automatic txn(input logic [2:0] t_op, input logic [31:0] t_addr,
                       input logic [31:0] t_wdata, input int delay,
                       input logic [31:0] word, input logic lit_en,
                       input logic [31:0] lit_rdata, input logic rv_in_resp);
        logic is_st;
        logic to;
        int   n;
        is_st = (t_op >= 3'd5);
        // accept cycle
        step();
        req_valid = 1'b1;
        op        = t_op;
        addr      = t_addr;
        wdata     = t_wdata;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        exp_idle(1'b1);
        if (ref_mis(t_op, t_addr)) begin
            step();
            req_valid = rv_in_resp;
            op        = 3'($urandom);
            addr      = $urandom;
            mem_ack   = 1'($urandom);
            e_ready = 1'b0; e_stall = 1'b0; e_req = 1'b0; e_rsp = 1'b1;
            e_rdata = 32'd0; e_aerr = 1'b1; e_berr = 1'b0;
            return;
        end
`ifdef LSU_TIMEOUT_EN
        to = (delay > TB_TO - 1);
`else
        to = 1'b0;
`endif
        n = to ? TB_TO : delay + 1;
        for (int k = 0; k < n; k++) begin
            step();
            req_valid = 1'($urandom);
            op        = 3'($urandom);
            addr      = $urandom;
            mem_ack   = (!to && k == delay);
            mem_rdata = (k == delay) ? word : $urandom;
            e_ready = 1'b0; e_stall = 1'b1; e_req = 1'b1; e_rsp = 1'b0;
            e_we    = is_st;
            e_be    = ref_be(t_op, t_addr);
            e_addr  = t_addr - (t_addr % 4);
            e_wdata = ref_wdata(t_op, t_wdata);
        end
        step();
        req_valid = rv_in_resp;
        op        = 3'($urandom);
        addr      = $urandom;
        mem_ack   = 1'($urandom);
        mem_rdata = $urandom;
        e_ready = 1'b0; e_stall = 1'b0; e_req = 1'b0; e_rsp = 1'b1;
        e_aerr  = 1'b0;
        e_berr  = to;
        if (to || is_st)  e_rdata = 32'd0;
        else if (lit_en)  e_rdata = lit_rdata;
        else              e_rdata = ref_load(t_op, t_addr, word);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        op        = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        step();
        step();
        e_chk = 1'b1;
        exp_reset_state();
        step();
        reset = 1'b0;
        exp_reset_state();

        // Hand-computed cases.
        txn(3'd0, 32'h103, 32'h0, 0, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80, 1'b0);
        txn(3'd3, 32'h202, 32'h0, 1, 32'h9ABC_0000, 1'b1, 32'h0000_9ABC, 1'b1);
        txn(3'd2, 32'h202, 32'h0, 0, 32'h9ABC_0000, 1'b1, 32'hFFFF_9ABC, 1'b0);
        txn(3'd5, 32'h301, 32'hAA, 3, 32'h0, 1'b0, 32'h0, 1'b0);
        txn(3'd4, 32'h402, 32'h0, 0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle_cycles(2);

        // Reset during the second ACCESS cycle, late ack afterwards.
        step();
        req_valid = 1'b1; op = 3'd4; addr = 32'h500; mem_ack = 1'b0;
        exp_idle(1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            reset     = (k == 1);
            e_ready = 1'b0; e_stall = 1'b1; e_req = 1'b1; e_rsp = 1'b0;
            e_we = 1'b0; e_be = 4'hF; e_addr = 32'h500;
        end
        step();
        reset   = 1'b0;
        mem_ack = 1'b1;
        exp_reset_state();
        step();
        mem_ack = 1'b0;
        exp_reset_state();

        // Long wait: completes normally without the timeout, times out with it.
        txn(3'd7, 32'h600, 32'h1234_5678, 20, 32'h0, 1'b0, 32'h0, 1'b0);
        txn(3'd6, 32'h702, 32'hBEEF, 0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            txn(3'($urandom_range(0, 7)), $urandom, $urandom,
`ifdef LSU_TIMEOUT_EN
                $urandom_range(0, 6),
`else
                $urandom_range(0, 5),
`endif
                $urandom, 1'b0, 32'h0, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(2);
        step();
        e_chk = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
